tmds_video_encoder: RTL
=======================

// Module: tmds_video_encoder
// PURPOSE
//  DVI/HDMI output stage fed directly by the scandoubler.
//  Takes its hs/vs/de and 1-bit video, maps the video to 24-bit RGB
//  foreground/background colours and TMDS-encodes three channels.
//  Produces one 10-bit symbol per channel per pixel enable.
//  The three symbols feed the 10:1 serialisers (DDR, vendor primitive,
//  outside this block).
// PARAMETERS
//  FG_RGB      24'hFFFFFF  colour for v_in=1 ({R,G,B}, 8 bits each)
//  BG_RGB      24'h000000  colour for v_in=0
//  DIM_SHIFT   1           right shift applied to colour when dim=1
//  SYNC_INVERT 1           1: hs_in/vs_in are active-low and are inverted before encoding
// PORTS
//  clk      in   1   system clock; same clock as the scandoubler
//  reset    in   1   synchronous, active-high
//  ce_pix   in   1   pixel enable; one symbol per asserted cycle
//  hs_in    in   1   horizontal sync from the scandoubler
//  vs_in    in   1   vertical sync from the scandoubler
//  de_in    in   1   display enable
//  v_in     in   1   pixel video bit
//  dim      in   1   halves intensity (scanline/OSD dimming)
//  tmds_r   out  10  red-channel symbol (ch2), bit 0 transmitted first
//  tmds_g   out  10  green-channel symbol (ch1)
//  tmds_b   out  10  blue-channel symbol (ch0), carries sync
//  sym_vld  out  1   pulses for 1 clk when new symbols are presented
// BEHAVIOUR
//  - All state advances only on cycles with ce_pix=1; otherwise all registers hold.
//  - Reset values:
//    - tmds_r/g/b = 10'b1101010100 (control 00); sym_vld=0
//    - all disparity counters = 0; pipeline de bits = 0
//  - Stage 1 (ce_pix):
//    - rgb = v_in ? FG_RGB : BG_RGB; if dim, each 8-bit field >> DIM_SHIFT
//    - register rgb, de, and c = {vs,hs} (inverted if SYNC_INVERT)
//  - Stage 2 (ce_pix): per channel, N1(x) = number of ones in x
//    - transition minimise: if N1(D)>4 or (N1(D)==4 and D[0]==0) use XNOR, else XOR
//    - qm[0]=D[0]; qm[i]=qm[i-1] op D[i]; qm[8] = 0 for XNOR, 1 for XOR
//    - cnt is signed 5-bit; n1=N1(qm[7:0]), n0=8-n1
//    - if cnt==0 or n1==n0:
//      - out = {~qm8, qm8, qm8 ? qm[7:0] : ~qm[7:0]}
//      - cnt += qm8 ? n1-n0 : n0-n1
//    - elif (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
//      - out = {1, qm8, ~qm[7:0]}
//      - cnt += 2*qm8 + n0-n1
//    - else: out = {0, qm8, qm[7:0]}; cnt += n1-n0 - 2*(~qm8)
//  - de=0 in stage 2:
//    - symbol chosen by control pair c1c0, and cnt is cleared to 0
//    - 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011
//    - blue uses c={vs,hs}; red and green use 00
//  - Latency: 2 ce_pix cycles, input to tmds_*. sym_vld = registered ce_pix
//    (high the clk after the stage-2 update).
//  - Channels are fully independent; each keeps its own cnt.
//  - cnt range stays within [-10,+10]; no overflow handling is needed,
//    but the width must be exactly 5 bits signed.
//  - de rising mid-line: first data symbol starts at cnt=0.
//  - de falling: the control symbol follows immediately.
//  - reset mid-line: outputs return to control-00 on the next clk,
//    independent of ce_pix.
//  - ce_pix held low: outputs are frozen, sym_vld=0.
// TESTING
//  - Reset, then de=0, hs/vs inactive (1 with SYNC_INVERT) -> tmds_b=1101010100;
//    r/g same; sym_vld=0 until ce.
//  - de=0, hs_in=0 (active), vs_in=1, 2 ce later -> tmds_b=0010101011
//    (c=01); vs+hs active -> 1010101011.
//  - BG=000000, v_in=0, de=1 from cnt=0 -> blue symbols 0x100, 0x3FF, 0x100, 0x3FF...;
//    cnt sequence -8, +2, -6...
//  - FG=FFFFFF, v_in=1 from cnt=0 -> first symbol 0x200; cnt=-8 after it.
//  - dim=1, FG=FFFFFF, DIM_SHIFT=1 -> encoded byte 0x7F;
//    compare against the reference encoder model for 1000 random pixels/dim.
//  - ce_pix toggling 1-in-2, and reset asserted mid-line -> symbols match
//    a ce-every-cycle run decimated; post-reset control-00 and cnt=0.

Source files
------------

// File: rtl/tmds_video_encoder.sv
// DVI/HDMI output stage: maps the scandoubler's 1-bit video to RGB and emits
// three TMDS 10-bit symbols per pixel enable (two-stage pipeline).
module tmds_video_encoder #(
    parameter logic [23:0] FG_RGB      = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB      = 24'h000000,
    parameter int unsigned DIM_SHIFT   = 1,
    parameter bit          SYNC_INVERT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       de_in,
    input  logic       v_in,
    input  logic       dim,
    output logic [9:0] tmds_r,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_b,
    output logic       sym_vld
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef struct packed {
        logic [9:0]        sym;
        logic signed [4:0] cnt;
    } enc_t;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

    function automatic enc_t encode(input logic [7:0] d, input logic signed [4:0] cnt);
        enc_t              res;
        logic [3:0]        n1d;
        logic [3:0]        n1q;
        logic              use_xnor;
        logic [8:0]        qm;
        logic signed [4:0] diff;
        n1d = '0;
        for (int unsigned i = 0; i < 8; i++) n1d = n1d + 4'(d[i]);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        qm = '0;
        qm[0] = d[0];
        for (int unsigned i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
        n1q = '0;
        for (int unsigned i = 0; i < 8; i++) n1q = n1q + 4'(qm[i]);
        // n1 - n0 == 2*n1 - 8; modular 5-bit arithmetic keeps the sign right
        diff = signed'({n1q, 1'b0} - 5'd8);
        if (cnt == 5'sd0 || diff == 5'sd0) begin
            res.sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            res.cnt = qm[8] ? cnt + diff : cnt - diff;
        end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
            res.sym = {1'b1, qm[8], ~qm[7:0]};
            res.cnt = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            res.sym = {1'b0, qm[8], qm[7:0]};
            res.cnt = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
        end
        return res;
    endfunction

    logic [23:0]       pix_rgb;
    logic [1:0]        pix_c;
    logic [23:0]       rgb_s1;
    logic              de_s1;
    logic [1:0]        c_s1;
    logic signed [4:0] cnt [3];
    logic [9:0]        sym [3];
    enc_t              enc [3];

    always_comb begin
        pix_rgb = v_in ? FG_RGB : BG_RGB;
        if (dim)
            pix_rgb = {pix_rgb[23:16] >> DIM_SHIFT, pix_rgb[15:8] >> DIM_SHIFT,
                       pix_rgb[7:0] >> DIM_SHIFT};
        pix_c = {vs_in, hs_in} ^ {2{SYNC_INVERT}};
    end

    // Channel 0 = blue, 1 = green, 2 = red
    always_comb begin
        for (int unsigned ch = 0; ch < 3; ch++)
            enc[ch] = encode(rgb_s1[8*ch +: 8], cnt[ch]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_s1  <= '0;
            de_s1   <= 1'b0;
            c_s1    <= '0;
            sym_vld <= 1'b0;
            for (int unsigned ch = 0; ch < 3; ch++) begin
                cnt[ch] <= '0;
                sym[ch] <= CTRL_00;
            end
        end else begin
            sym_vld <= ce_pix;
            if (ce_pix) begin
                rgb_s1 <= pix_rgb;
                de_s1  <= de_in;
                c_s1   <= pix_c;
                for (int unsigned ch = 0; ch < 3; ch++) begin
                    if (de_s1) begin
                        sym[ch] <= enc[ch].sym;
                        cnt[ch] <= enc[ch].cnt;
                    end else begin
                        sym[ch] <= (ch == 0) ? ctrl_sym(c_s1) : CTRL_00;
                        cnt[ch] <= '0;
                    end
                end
            end
        end
    end

    assign tmds_b = sym[0];
    assign tmds_g = sym[1];
    assign tmds_r = sym[2];

endmodule
